// File: rtl/md_unit.sv
// md_unit -- multiply/divide unit for the EX stage.
//
// Runs mult/multu/div/divu with fixed multi-cycle latencies, owns the
// architectural HI/LO registers and services mthi/mtlo/mfhi/mflo.
// The arithmetic result is computed in the start cycle and parked in
// hi_tmp/lo_tmp. It only becomes visible in hi/lo when the countdown
// expires, so the pipeline observes the documented latency.
//
// Ports:
//   clk, reset    clock; synchronous active-high reset
//   req           exception flush: blocks new starts and mthi/mtlo writes
//   E_MDop[3:0]   0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 none
//   E_RD1/E_RD2   rs / rt operands
//   md_start      combinational: an arithmetic op is accepted this cycle
//   md_busy       registered: an operation is in flight
//   md_out        combinational: HI for mfhi, LO for mflo, else 0
//   hi, lo        architectural HI/LO
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  E_MDop,
  input  logic [31:0] E_RD1,
  input  logic [31:0] E_RD2,
  output logic        md_start,
  output logic        md_busy,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic [31:0] hi_tmp_reg, hi_tmp_next;
  logic [31:0] lo_tmp_reg, lo_tmp_next;

  logic        is_arith;
  logic [63:0] prod_s, prod_u;
  logic        signed_div, a_neg, b_neg;
  logic [31:0] abs_a, abs_b, uq, ur, quot, rem;
  logic [63:0] result;

  assign is_arith = (E_MDop >= OP_MULT) && (E_MDop <= OP_DIVU);
  assign md_busy  = (state_reg == BUSY);
  assign md_start = is_arith && !md_busy && !req;

  // Products are formed at full 64-bit width from explicitly extended operands.
  assign prod_s = $signed({{32{E_RD1[31]}}, E_RD1}) * $signed({{32{E_RD2[31]}}, E_RD2});
  assign prod_u = {32'b0, E_RD1} * {32'b0, E_RD2};

  // One unsigned divider serves both div and divu. A signed divide runs on
  // magnitudes and fixes the signs afterwards. That also gives the required
  // 0x80000000 / -1 result: |a|=0x80000000, quotient sign positive, and the
  // bits wrap back to 0x80000000.
  assign signed_div = (E_MDop == OP_DIV);
  assign a_neg      = signed_div && E_RD1[31];
  assign b_neg      = signed_div && E_RD2[31];
  assign abs_a      = a_neg ? -E_RD1 : E_RD1;
  assign abs_b      = b_neg ? -E_RD2 : E_RD2;
  assign uq         = (abs_b == 32'd0) ? 32'd0 : abs_a / abs_b;
  assign ur         = (abs_b == 32'd0) ? 32'd0 : abs_a % abs_b;
  assign quot       = (a_neg ^ b_neg) ? -uq : uq;
  assign rem        = a_neg ? -ur : ur;

  always_comb begin
    result = {hi_reg, lo_reg};
    case (E_MDop)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV, OP_DIVU: begin
        // A zero divisor leaves HI/LO unchanged, but the op still runs full length.
        if (E_RD2 != 32'd0) result = {rem, quot};
      end
      default:  result = {hi_reg, lo_reg};
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    hi_tmp_next = hi_tmp_reg;
    lo_tmp_next = lo_tmp_reg;
    case (state_reg)
      IDLE: begin
        if (md_start) begin
          hi_tmp_next = result[63:32];
          lo_tmp_next = result[31:0];
          cnt_next    = (E_MDop <= OP_MULTU) ? MULT_CNT : DIV_CNT;
          state_next  = BUSY;
        end else if (!req) begin
          if (E_MDop == OP_MTHI) hi_next = E_RD1;
          if (E_MDop == OP_MTLO) lo_next = E_RD1;
        end
      end
      BUSY: begin
        // MD ops arriving while busy are ignored; req cannot cancel the commit.
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          hi_next    = hi_tmp_reg;
          lo_next    = lo_tmp_reg;
          cnt_next   = 4'd0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      hi_reg     <= 32'd0;
      lo_reg     <= 32'd0;
      hi_tmp_reg <= 32'd0;
      lo_tmp_reg <= 32'd0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      hi_tmp_reg <= hi_tmp_next;
      lo_tmp_reg <= lo_tmp_next;
    end
  end

  always_comb begin
    md_out = 32'd0;
    if (E_MDop == OP_MFHI) md_out = hi_reg;
    if (E_MDop == OP_MFLO) md_out = lo_reg;
  end

  assign hi = hi_reg;
  assign lo = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit. A behavioural model tracks HI/LO and the
// remaining busy time using plain integer arithmetic. A negedge process
// compares every DUT output against the model on every cycle after reset.
// The stimulus also checks hand-computed literals.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] rd1 = 32'd0;
  logic [31:0] rd2 = 32'd0;
  logic        md_start, md_busy;
  logic [31:0] md_out, hi, lo;

  int n_vec  = 0;
  int n_fail = 0;

  md_unit dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .E_MDop   (op),
    .E_RD1    (rd1),
    .E_RD2    (rd2),
    .md_start (md_start),
    .md_busy  (md_busy),
    .md_out   (md_out),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference arithmetic on 64-bit integers.
  function automatic logic [63:0] md_result(input logic [3:0] o, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] h,
                                            input logic [31:0] l);
    longint sa, sb, ua, ub, q, r;
    logic [63:0] r64;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    r64 = {h, l};
    case (o)
      4'd1: r64 = sa * sb;
      4'd2: r64 = ua * ub;
      4'd3: if (b != 32'd0) begin
        q = sa / sb;
        r = sa % sb;
        r64 = {r[31:0], q[31:0]};
      end
      4'd4: if (b != 32'd0) begin
        q = ua / ub;
        r = ua % ub;
        r64 = {r[31:0], q[31:0]};
      end
      default: r64 = {h, l};
    endcase
    return r64;
  endfunction

  // Model state.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  int          m_left = 0;
  bit          model_ok = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_hi <= 32'd0; m_lo <= 32'd0; m_left <= 0; model_ok <= 1'b1;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_hi <= p_hi; m_lo <= p_lo;
      end
    end else if (!req && op >= 4'd1 && op <= 4'd4) begin
      {p_hi, p_lo} <= md_result(op, rd1, rd2, m_hi, m_lo);
      m_left <= (op <= 4'd2) ? 5 : 10;
    end else if (!req && op == 4'd5) begin
      m_hi <= rd1;
    end else if (!req && op == 4'd6) begin
      m_lo <= rd1;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("busy",  32'(md_busy), 32'(m_left != 0));
      check("start", 32'(md_start), 32'(op >= 4'd1 && op <= 4'd4 && m_left == 0 && !req));
      check("md_out", md_out, (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0);
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  task automatic start_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input string nm);
    op = o; rd1 = a; rd2 = b;
    #1;
    check({nm, "_start"}, 32'(md_start), 32'd1);
    @(posedge clk); #1;
    op = 4'd0;
  endtask

  // Counts busy cycles from the current sample on. It can pulse req in busy
  // cycle req_at and present bop to the DUT while busy.
  task automatic wait_idle(input int req_at, input logic [3:0] bop, input int exp_n,
                           input string nm);
    int n = 0;
    op = bop;
    while (md_busy && n < 40) begin
      n++;
      req = (n == req_at);
      @(posedge clk); #1;
    end
    req = 1'b0; op = 4'd0;
    check({nm, "_busycycles"}, 32'(n), 32'(exp_n));
  endtask

  task automatic single(input logic [3:0] o, input logic [31:0] a, input logic rq);
    op = o; rd1 = a; req = rq;
    @(posedge clk); #1;
    op = 4'd0; req = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", 32'(md_busy), 32'd0);

    // mult -2 * 3
    start_op(4'd1, 32'hFFFF_FFFE, 32'd3, "mult");
    wait_idle(-1, 4'd0, 5, "mult");
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    // back-to-back multu, started in the first free cycle
    start_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu");
    wait_idle(-1, 4'd0, 5, "multu");
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    // div -7 / 2
    start_op(4'd3, 32'hFFFF_FFF9, 32'd2, "div");
    wait_idle(-1, 4'd0, 10, "div");
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_lo", lo, 32'hFFFF_FFFD);

    // signed overflow case, with mthi presented while busy (ignored)
    start_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "divov");
    wait_idle(-1, 4'd5, 10, "divov");
    check("divov_hi", hi, 32'h0000_0000);
    check("divov_lo", lo, 32'h8000_0000);

    // divu by zero keeps the prior HI/LO
    single(4'd5, 32'h11, 1'b0);
    single(4'd6, 32'h22, 1'b0);
    start_op(4'd4, 32'd7, 32'd0, "divu0");
    wait_idle(-1, 4'd0, 10, "divu0");
    check("divu0_hi", hi, 32'h11);
    check("divu0_lo", lo, 32'h22);

    // mthi then mflo / mfhi; then mthi blocked by req
    single(4'd5, 32'h1234, 1'b0);
    op = 4'd8; #1;
    check("mflo_out", md_out, 32'h22);
    @(posedge clk); #1;
    op = 4'd7; #1;
    check("mfhi_out", md_out, 32'h1234);
    @(posedge clk); #1;
    single(4'd5, 32'hBEEF, 1'b1);
    op = 4'd7; #1;
    check("mfhi_req_out", md_out, 32'h1234);
    @(posedge clk); #1;
    op = 4'd0;

    // div 100 / 7 with req pulsed in busy cycle 3
    start_op(4'd3, 32'd100, 32'd7, "divreq");
    wait_idle(3, 4'd0, 10, "divreq");
    check("divreq_hi", hi, 32'd2);
    check("divreq_lo", lo, 32'd14);

    // mult blocked by req
    op = 4'd1; rd1 = 32'd5; rd2 = 32'd6; req = 1'b1; #1;
    check("multreq_start", 32'(md_start), 32'd0);
    @(posedge clk); #1;
    op = 4'd0; req = 1'b0;
    check("multreq_busy", 32'(md_busy), 32'd0);
    check("multreq_hi", hi, 32'd2);

    // reserved opcode behaves as none
    op = 4'd9; #1;
    check("op9_start", 32'(md_start), 32'd0);
    @(posedge clk); #1;
    op = 4'd0;
    check("op9_busy", 32'(md_busy), 32'd0);

    // reset during busy cycle 2 discards the pending mult result
    start_op(4'd1, 32'd3, 32'd4, "multrst");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rstmid_busy", 32'(md_busy), 32'd0);
    check("rstmid_hi", hi, 32'd0);
    check("rstmid_lo", lo, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("rstmid_late_lo", lo, 32'd0);
    check("rstmid_late_busy", 32'(md_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit in the EX stage of the P8 pipeline, consuming the operand and `E_MDop` fields registered by the D→E pipeline register. It runs MIPS mult/multu/div/divu with fixed multi-cycle latencies, owns the HI/LO registers, and handles mthi/mtlo/mfhi/mflo. It reports `md_start`/`md_busy` back to the hazard unit so that D-stage MD instructions stall. It also honours the exception-flush `req` so that no new HI/LO side effect commits for a flushed instruction.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy duration for mult/multu.
- `DIV_CYCLES`, 10: busy duration for div/divu.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high; clock clk.
- `req`  in  1  exception/interrupt flush. Blocks any new start or mthi/mtlo write this cycle.
- `E_MDop`  in  4  operation select:
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu
  - 5 mthi, 6 mtlo, 7 mfhi, 8 mflo
  - 9–15 treated as none
- `E_RD1`  in  32  forwarded rs operand.
- `E_RD2`  in  32  forwarded rt operand.
- `md_start`  out  1  combinational. High when `E_MDop` is 1–4, `md_busy`=0 and `req`=0.
- `md_busy`  out  1  registered. Operation in flight.
- `md_out`  out  32  combinational. HI when `E_MDop`=7, LO when 8, else 0.
- `hi`  out  32  architectural HI.
- `lo`  out  32  architectural LO.

## Operation
- State: `hi`, `lo`, `hi_tmp`, `lo_tmp`, 4-bit `cnt`, `md_busy`.
- IDLE (`md_busy`=0): on `md_start`, compute the result from `E_RD1`/`E_RD2` and store it in `hi_tmp`/`lo_tmp`, load `cnt` with the op's cycle count, and set `md_busy`.
- BUSY: `cnt` decrements on each edge. On the edge where `cnt`==1:
  - `hi`←`hi_tmp`, `lo`←`lo_tmp`
  - `md_busy`←0, `cnt`←0
- Arithmetic:
  - mult: {hi,lo} = signed 32×32 → 64-bit product.
  - multu: {hi,lo} = unsigned 32×32 → 64-bit product.
  - div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: lo = unsigned quotient; hi = unsigned remainder.
- Div corner cases:
  - Divisor 0: `hi_tmp`/`lo_tmp` take the current hi/lo, so the result is unchanged. The op still takes `DIV_CYCLES`.
  - 0x80000000 / 0xFFFFFFFF (signed): lo=0x80000000, hi=0.
- mthi/mtlo: write `E_RD1` to hi/lo at the next edge when `req`=0 and `md_busy`=0. No busy is generated.
- mfhi/mflo: `md_out` shows the current hi/lo combinationally. No state change.
- MD ops are not issued while busy: the hazard unit stalls any D-stage MD instruction while `md_start|md_busy`. If `E_MDop`≠0 arrives while busy anyway, it is ignored.
- `req` while busy: the in-flight operation completes and commits normally; `req` only blocks new commits.
- `req` with `md_start` candidate: no start and no state change; `md_start` reads 0.

## Timing
- Reset values:
  - `hi`=0, `lo`=0, `hi_tmp`=0, `lo_tmp`=0
  - `cnt`=0, `md_busy`=0
  - `md_start`=0 and `md_out`=0 follow combinationally while `E_MDop`=0.
- Reset mid-operation: everything clears on that edge and the pending result is discarded.
- mult started at edge T0:
  - `md_busy` is high for exactly `MULT_CYCLES` cycles, edges T0+1 … T0+5 inclusive of the drop.
  - hi/lo update and `md_busy` falls at edge T0+5.
  - div is the same with 10 cycles.
- mthi/mtlo: 1-edge latency. mfhi in the cycle after mthi sees the new value.
- A new start is accepted in the first cycle after `md_busy` falls (back-to-back).
- Simultaneous `reset` and `md_start`: reset wins.

## Test plan
- Reset, then mult with RD1=0xFFFFFFFE (−2), RD2=3 → `md_start`=1 for one cycle. `md_busy` is high for 5 cycles. Afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu with 0xFFFFFFFF × 0xFFFFFFFF → after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- div with −7 / 2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0 with prior hi=0x11, lo=0x22 → busy for 10 cycles, then hi=0x11, lo=0x22.
- mthi 0x1234 then mflo/mfhi in the following cycles → `md_out`=0x1234 for mfhi. Same sequence with `req`=1 on the mthi cycle → hi unchanged.
- div started, then `req` pulsed at busy cycle 3 → result still commits at cycle 10. mult presented with `req`=1 → `md_start`=0, `md_busy` stays 0.
- mult started, then reset asserted at busy cycle 2 → next cycle `md_busy`=0, hi=lo=0, and no later commit occurs.
